regop_sequencer: RTL and testbench



---
 rtl/regop_pkg.sv | 15 +
 rtl/regop_alu.sv | 46 ++++
 rtl/regop_sequencer.sv | 126 ++++++++++++
 tb/tb_regop_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regop_pkg.sv
// Shared opcodes and FSM state encoding for the register-op sequencer.
package regop_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_NOP = 3'd6;
   localparam logic [2:0] OP_LDI = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE} state_e;

endpackage

// File: rtl/regop_alu.sv
// Combinational ALU for the sequencer; carry output exists only with REGOP_FLAGS_EN.
module regop_alu
   import regop_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] imm,
`ifdef REGOP_FLAGS_EN
   output logic          carry,
`endif
   output logic [DW-1:0] y
);

`ifdef REGOP_FLAGS_EN
   // One extra bit holds carry-out for ADD and borrow for SUB.
   logic [DW:0] sum_w;
   logic [DW:0] diff_w;
   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};
   assign carry  = (op == OP_ADD) ? sum_w[DW] :
                   (op == OP_SUB) ? diff_w[DW] : 1'b0;
`else
   logic [DW-1:0] sum_w;
   logic [DW-1:0] diff_w;
   assign sum_w  = a + b;
   assign diff_w = a - b;
`endif

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = sum_w[DW-1:0];
         OP_SUB:  y = diff_w[DW-1:0];
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_MOV:  y = a;
         OP_LDI:  y = imm;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/regop_sequencer.sv
// Four-cycle register-to-register command sequencer driving a register bank.
// Optional REGOP_FLAGS_EN adds zero/carry flag outputs.
module regop_sequencer
   import regop_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_src1,
   input  logic [AW-1:0] cmd_src2,
   input  logic [AW-1:0] cmd_dst,
   input  logic [DW-1:0] cmd_imm,
   output logic [AW-1:0] sr1,
   output logic [AW-1:0] sr2,
   input  logic [DW-1:0] rdData1,
   input  logic [DW-1:0] rdData2,
   output logic [AW-1:0] dr,
   output logic          write,
   output logic [DW-1:0] wrData,
   output logic          done,
`ifdef REGOP_FLAGS_EN
   output logic          flag_z,
   output logic          flag_c,
`endif
   output logic [DW-1:0] result
);

   state_e        state_q;
   logic [2:0]    op_q;
   logic [AW-1:0] src1_q;
   logic [AW-1:0] src2_q;
   logic [AW-1:0] dst_q;
   logic [DW-1:0] imm_q;
   logic [DW-1:0] opa_q;
   logic [DW-1:0] opb_q;
   logic [DW-1:0] result_q;
   logic [DW-1:0] alu_y;

`ifdef REGOP_FLAGS_EN
   logic alu_carry;
   logic flag_z_q;
   logic flag_c_q;
`endif

   regop_alu #(
      .DW (DW)
   ) u_alu (
      .op    (op_q),
      .a     (opa_q),
      .b     (opb_q),
      .imm   (imm_q),
`ifdef REGOP_FLAGS_EN
      .carry (alu_carry),
`endif
      .y     (alu_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         dst_q    <= '0;
         imm_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
`ifdef REGOP_FLAGS_EN
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  src1_q  <= cmd_src1;
                  src2_q  <= cmd_src2;
                  dst_q   <= cmd_dst;
                  imm_q   <= cmd_imm;
                  state_q <= ST_READ;
               end
            end
            ST_READ: begin
               opa_q   <= rdData1;
               opb_q   <= rdData2;
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               // NOP leaves result and flags untouched.
               if (op_q != OP_NOP) begin
                  result_q <= alu_y;
`ifdef REGOP_FLAGS_EN
                  flag_z_q <= (alu_y == '0);
                  flag_c_q <= alu_carry;
`endif
               end
               state_q <= ST_WRITE;
            end
            ST_WRITE: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign sr1       = src1_q;
   assign sr2       = src2_q;
   assign dr        = dst_q;
   assign wrData    = result_q;
   assign result    = result_q;
   // Gated by rst so a reset landing on WRITE never touches the bank.
   assign write     = (state_q == ST_WRITE) && (op_q != OP_NOP) && !rst;
   assign done      = (state_q == ST_WRITE) && !rst;
`ifdef REGOP_FLAGS_EN
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;
`endif

endmodule

// File: tb/tb_regop_sequencer.sv
// Self-checking bench: sequencer plus a 4x32 bank, compared each cycle to a behavioural model.
module tb_regop_sequencer;
   import regop_pkg::*;

   localparam int DW = 32;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
   logic [DW-1:0] cmd_imm;
   logic [AW-1:0] sr1, sr2, dr;
   logic [DW-1:0] rdData1, rdData2, wrData, result;
   logic          write, done;
`ifdef REGOP_FLAGS_EN
   logic          flag_z, flag_c;
`endif

   always #5 clk = ~clk;

   regop_sequencer #(
      .DW (DW),
      .AW (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src1  (cmd_src1),
      .cmd_src2  (cmd_src2),
      .cmd_dst   (cmd_dst),
      .cmd_imm   (cmd_imm),
      .sr1       (sr1),
      .sr2       (sr2),
      .rdData1   (rdData1),
      .rdData2   (rdData2),
      .dr        (dr),
      .write     (write),
      .wrData    (wrData),
      .done      (done),
`ifdef REGOP_FLAGS_EN
      .flag_z    (flag_z),
      .flag_c    (flag_c),
`endif
      .result    (result)
   );

   // Register bank: combinational reads, write on the rising edge.
   logic [DW-1:0] bank [4] = '{default: '0};
   assign rdData1 = bank[sr1];
   assign rdData2 = bank[sr2];
   always @(posedge clk) if (write) bank[dr] <= wrData;

   // Behavioural model: m_off is the cycle offset since acceptance (1..3), -1 when idle.
   int            m_off = -1;
   logic [2:0]    m_op;
   logic [AW-1:0] m_src1, m_src2, m_dst;
   logic [DW-1:0] m_pend, m_result;
   logic [DW-1:0] m_bank [4] = '{default: '0};
   logic          m_zp, m_cp, m_z, m_c;
   bit            m_after_rst = 0;
   bit            started = 0;
   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;

   function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] imm);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_MOV:  return a;
         OP_LDI:  return imm;
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      if (done === 1'b1) done_cnt++;
      chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, m_off < 0});
      chk("done", {63'd0, done}, {63'd0, (m_off == 3) && !rst});
      chk("write", {63'd0, write}, {63'd0, (m_off == 3) && (m_op != OP_NOP) && !rst});
      chk("result", {32'd0, result}, {32'd0, m_result});
      if (m_off == 1) begin
         chk("sr1", {62'd0, sr1}, {62'd0, m_src1});
         chk("sr2", {62'd0, sr2}, {62'd0, m_src2});
      end
      if (m_off == 3 && !rst) begin
         chk("dr", {62'd0, dr}, {62'd0, m_dst});
         if (m_op != OP_NOP) chk("wrData", {32'd0, wrData}, {32'd0, m_pend});
      end
      if (m_after_rst) begin
         chk("rst_sr1", {62'd0, sr1}, 64'd0);
         chk("rst_sr2", {62'd0, sr2}, 64'd0);
         chk("rst_dr", {62'd0, dr}, 64'd0);
         chk("rst_wrData", {32'd0, wrData}, 64'd0);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("bank%0d", i), {32'd0, bank[i]}, {32'd0, m_bank[i]});
`ifdef REGOP_FLAGS_EN
      chk("flag_z", {63'd0, flag_z}, {63'd0, m_z});
      chk("flag_c", {63'd0, flag_c}, {63'd0, m_c});
`endif
   endtask

   task automatic model_update();
      m_after_rst = 0;
      if (rst) begin
         m_off = -1; m_result = '0; m_z = 0; m_c = 0; m_after_rst = 1; started = 1;
      end else if (m_off == 3) begin
         if (m_op != OP_NOP) m_bank[m_dst] = m_pend;
         m_off = -1;
      end else if (m_off >= 1) begin
         m_off++;
         if (m_off == 3 && m_op != OP_NOP) begin
            m_result = m_pend; m_z = m_zp; m_c = m_cp;
         end
      end else if (cmd_valid) begin
         m_op = cmd_op; m_src1 = cmd_src1; m_src2 = cmd_src2; m_dst = cmd_dst;
         m_pend = ref_alu(cmd_op, m_bank[cmd_src1], m_bank[cmd_src2], cmd_imm);
         m_zp = (m_pend == 0);
         if (cmd_op == OP_ADD)
            m_cp = (longint'({32'd0, m_bank[cmd_src1]}) + longint'({32'd0, m_bank[cmd_src2]}))
                   > 64'hFFFF_FFFF;
         else if (cmd_op == OP_SUB) m_cp = m_bank[cmd_src1] < m_bank[cmd_src2];
         else m_cp = 0;
         m_off = 1;
      end
   endtask

   // Inputs are set at posedge+1, checked at posedge+2, then the edge advances the model.
   task automatic tick();
      #1;
      if (started) check_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_cmd(input logic [2:0] op, input int s1, input int s2, input int d,
                         input logic [DW-1:0] imm);
      int n = 0;
      cmd_valid = 1; cmd_op = op; cmd_src1 = AW'(s1); cmd_src2 = AW'(s2);
      cmd_dst = AW'(d); cmd_imm = imm;
      while (m_off >= 0 && n < 8) begin tick(); n++; end
      chk("accept_bound", {63'd0, n >= 8}, 64'd0);
      tick();
      cmd_valid = 0; cmd_op = $urandom; cmd_imm = $urandom;
      n = 0;
      while (m_off >= 0 && n < 8) begin tick(); n++; end
      chk("complete_bound", {63'd0, n >= 8}, 64'd0);
   endtask

   initial begin
      int d0;
      rst = 1; cmd_valid = 0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
      cmd_imm = '0;
      tick(); tick();
      rst = 0;
      tick();
      chk("reset_ready", {63'd0, cmd_ready}, 64'd1);
      chk("reset_result", {32'd0, result}, 64'd0);

      d0 = done_cnt;
      do_cmd(OP_LDI, 0, 0, 1, 32'h5);
      do_cmd(OP_LDI, 0, 0, 2, 32'h3);
      do_cmd(OP_ADD, 1, 2, 3, 32'h0);
      chk("add_r3", {32'd0, bank[3]}, 64'h8);
      chk("add_done_pulses", 64'(done_cnt - d0), 64'd3);

      do_cmd(OP_LDI, 0, 0, 0, 32'hFFFF_FFFF);
      do_cmd(OP_LDI, 0, 0, 1, 32'h1);
      do_cmd(OP_ADD, 0, 1, 2, 32'h0);
      chk("wrap_r2", {32'd0, bank[2]}, 64'h0);
      chk("wrap_result", {32'd0, result}, 64'h0);
`ifdef REGOP_FLAGS_EN
      chk("wrap_z", {63'd0, flag_z}, 64'd1);
      chk("wrap_c", {63'd0, flag_c}, 64'd1);
`endif

      do_cmd(OP_LDI, 0, 0, 1, 32'h3);
      do_cmd(OP_LDI, 0, 0, 2, 32'h5);
      do_cmd(OP_SUB, 1, 2, 3, 32'h0);
      chk("sub_r3", {32'd0, bank[3]}, 64'hFFFF_FFFE);
`ifdef REGOP_FLAGS_EN
      chk("sub_z", {63'd0, flag_z}, 64'd0);
      chk("sub_c", {63'd0, flag_c}, 64'd1);
`endif

      do_cmd(OP_LDI, 0, 0, 1, 32'hA5A5_A5A5);
      do_cmd(OP_XOR, 1, 1, 1, 32'h0);
      chk("alias_r1", {32'd0, bank[1]}, 64'h0);
      d0 = done_cnt;
      do_cmd(OP_NOP, 0, 0, 2, 32'hDEAD_BEEF);
      chk("nop_r2", {32'd0, bank[2]}, 64'h5);
      chk("nop_done", 64'(done_cnt - d0), 64'd1);
      chk("nop_result_hold", {32'd0, result}, 64'h0);
`ifdef REGOP_FLAGS_EN
      chk("nop_z_hold", {63'd0, flag_z}, 64'd1);
`endif

      // Continuous valid with fields changing every cycle: one accept per 4 cycles.
      d0 = done_cnt;
      cmd_valid = 1;
      for (int i = 0; i < 20; i++) begin
         cmd_op = $urandom; cmd_src1 = $urandom; cmd_src2 = $urandom;
         cmd_dst = $urandom; cmd_imm = $urandom;
         tick();
      end
      cmd_valid = 0;
      chk("stream_done", 64'(done_cnt - d0), 64'd5);
      tick();

      // Reset landing on the WRITE cycle of ADD into R3.
      do_cmd(OP_LDI, 0, 0, 3, 32'h1234);
      do_cmd(OP_LDI, 0, 0, 1, 32'h1);
      do_cmd(OP_LDI, 0, 0, 2, 32'h2);
      cmd_valid = 1; cmd_op = OP_ADD; cmd_src1 = 1; cmd_src2 = 2; cmd_dst = 3;
      tick();
      cmd_valid = 0;
      tick(); tick();
      chk("pre_rst_phase", 64'(m_off), 64'd3);
      rst = 1;
      tick();
      rst = 0;
      tick();
      chk("rst_r3", {32'd0, bank[3]}, 64'h1234);
      chk("rst_result", {32'd0, result}, 64'h0);
      chk("rst_ready", {63'd0, cmd_ready}, 64'd1);

      for (int i = 0; i < 400; i++) begin
         cmd_valid = 1'($urandom); cmd_op = $urandom; cmd_src1 = $urandom;
         cmd_src2 = $urandom; cmd_dst = $urandom; cmd_imm = $urandom;
         rst = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 0; cmd_valid = 0;
      for (int i = 0; i < 6; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
